// File: rtl/ras_checkpointed.sv
// ras_checkpointed: return address stack with a FIFO of branch checkpoints for flush rollback
module ras_checkpointed #(
    parameter int DEPTH    = 8,
    parameter int NUM_CKPT = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] new_addr,
    input  logic              branch_fetched,
    input  logic              branch_retired,
    input  logic              flush,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              ckpt_full
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(NUM_CKPT);
    localparam int FW = $clog2(NUM_CKPT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [FW-1:0] F_MAX = FW'(NUM_CKPT);

    logic [IW-1:0]     idx_q, idx_d, st_idx, wr_idx;
    logic [CW-1:0]     cnt_q, cnt_d, st_cnt;
    logic              wr_en, enq, deq;
    logic [ADDR_W-1:0] lut_q [DEPTH];
    logic [IW-1:0]     ck_idx_q [NUM_CKPT];
    logic [CW-1:0]     ck_cnt_q [NUM_CKPT];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;

    // Post-update stack pointer/occupancy and the storage write for this cycle's push/pop
    always_comb begin
        st_idx = idx_q;
        st_cnt = cnt_q;
        wr_en  = 1'b0;
        wr_idx = idx_q + IW'(1);
        if (push && pop && cnt_q != '0) begin
            wr_en  = 1'b1;
            wr_idx = idx_q;
        end else if (push) begin
            wr_en  = 1'b1;
            st_idx = idx_q + IW'(1);
            st_cnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end else if (pop && cnt_q != '0) begin
            st_idx = idx_q - IW'(1);
            st_cnt = cnt_q - CW'(1);
        end
        wr_en = wr_en & ~flush;
    end

    // Checkpoint FIFO bookkeeping; a flush rolls back to the oldest checkpoint and empties the FIFO
    always_comb begin
        enq    = branch_fetched && (fcnt_q != F_MAX || branch_retired);
        deq    = branch_retired && fcnt_q != '0;
        idx_d  = flush ? ((fcnt_q != '0) ? ck_idx_q[head_q] : idx_q) : st_idx;
        cnt_d  = flush ? ((fcnt_q != '0) ? ck_cnt_q[head_q] : cnt_q) : st_cnt;
        head_d = flush ? '0 : head_q + PW'(deq);
        tail_d = flush ? '0 : tail_q + PW'(enq);
        fcnt_d = flush ? '0 : fcnt_q + FW'(enq) - FW'(deq);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            fcnt_q <= '0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Unreset storage: stack entries and checkpoint slots
    always_ff @(posedge clk) begin
        if (wr_en) lut_q[wr_idx] <= new_addr;
        if (enq && !flush) begin
            ck_idx_q[tail_q] <= st_idx;
            ck_cnt_q[tail_q] <= st_cnt;
        end
    end

    assign addr      = (cnt_q != '0) ? lut_q[idx_q] : '0;
    assign valid     = cnt_q != '0;
    assign ckpt_full = fcnt_q == F_MAX;
endmodule

// File: tb/tb_ras_checkpointed.sv
// tb_ras_checkpointed: randomized and directed checks of ras_checkpointed against a behavioural model
module tb_ras_checkpointed;
    localparam int DEPTH = 8;
    localparam int NUM_CKPT = 4;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1, push = 1'b0, pop = 1'b0, branch_fetched = 1'b0, branch_retired = 1'b0, flush = 1'b0;
    logic [ADDR_W-1:0] new_addr = '0;
    logic [ADDR_W-1:0] addr;
    logic valid, ckpt_full;

    ras_checkpointed #(.DEPTH(DEPTH), .NUM_CKPT(NUM_CKPT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
        .branch_fetched(branch_fetched), .branch_retired(branch_retired), .flush(flush),
        .addr(addr), .valid(valid), .ckpt_full(ckpt_full)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; int cnt;} ck_t;
    ck_t q[$];
    logic [ADDR_W-1:0] m_lut [DEPTH];
    int m_idx = 0, m_cnt = 0;
    int tests = 0, fails = 0;

    task automatic chk(input string n, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit p, input bit o, input logic [ADDR_W-1:0] a,
                       input bit bf, input bit br, input bit fl);
        rst = r; push = p; pop = o; new_addr = a;
        branch_fetched = bf; branch_retired = br; flush = fl;
        @(posedge clk);
        if (r) begin
            m_idx = 0; m_cnt = 0; q.delete();
        end else if (fl) begin
            if (q.size() > 0) begin
                m_idx = q[0].idx; m_cnt = q[0].cnt;
            end
            q.delete();
        end else begin
            if (bf && !br && q.size() == NUM_CKPT) begin
                tests++; fails++;
                $display("FAIL ckpt_overrun: branch fetched while checkpoint FIFO full");
            end
            if (p && o && m_cnt != 0) m_lut[m_idx] = a;
            else if (p) begin
                m_idx = (m_idx + 1) % DEPTH;
                m_lut[m_idx] = a;
                m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
            end else if (o && m_cnt != 0) begin
                m_idx = (m_idx + DEPTH - 1) % DEPTH;
                m_cnt = m_cnt - 1;
            end
            if (br && q.size() > 0) void'(q.pop_front());
            if (bf && q.size() < NUM_CKPT) q.push_back('{m_idx, m_cnt});
        end
        @(negedge clk);
        chk("addr", addr, (m_cnt != 0) ? m_lut[m_idx] : '0);
        chk("valid", valid, m_cnt != 0);
        chk("ckpt_full", ckpt_full, q.size() == NUM_CKPT);
    endtask

    initial begin
        bit p, o, bf, br, fl, r;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_addr", addr, 0); chk("rst_valid", valid, 0); chk("rst_full", ckpt_full, 0);
        cyc(0, 1, 0, 32'h100, 0, 0, 0);
        cyc(0, 1, 0, 32'h200, 0, 0, 0);
        chk("push2_addr", addr, 32'h200); chk("push2_valid", valid, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("pop1_addr", addr, 32'h100);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("pop2_addr", addr, 0); chk("pop2_valid", valid, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("pop_empty_addr", addr, 0); chk("pop_empty_valid", valid, 0);
        for (int i = 1; i <= 9; i++) cyc(0, 1, 0, 32'(i * 16), 0, 0, 0);
        chk("wrap_top", addr, 32'h90);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_pop_seq", addr, 32'(32'h90 - i * 16));
            cyc(0, 0, 1, 0, 0, 0, 0);
        end
        chk("wrap_empty_valid", valid, 0);
        cyc(0, 1, 0, 32'hA0, 0, 0, 0);
        cyc(0, 1, 1, 32'hB0, 0, 0, 0);
        chk("replace_addr", addr, 32'hB0); chk("replace_valid", valid, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("replace_pop_valid", valid, 0);
        cyc(0, 1, 0, 32'h40, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 32'h50, 0, 0, 0);
        cyc(0, 1, 0, 32'h60, 0, 0, 0);
        chk("pre_flush_addr", addr, 32'h60);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("flush_addr", addr, 32'h40); chk("flush_full", ckpt_full, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("flush_cnt1", valid, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        chk("ckpt_full4", ckpt_full, 1);
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk("ckpt_full_fr", ckpt_full, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("ckpt_retire1", ckpt_full, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);
        chk("ckpt_extra_retire", ckpt_full, 0);
        cyc(0, 1, 0, 32'h77, 0, 0, 0);
        cyc(0, 1, 0, 32'h88, 1, 0, 1);
        chk("flush_empty_addr", addr, 32'h77); chk("flush_empty_full", ckpt_full, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("flush_fifo_stayed_empty", valid, 0);
        cyc(0, 1, 0, 32'h99, 1, 0, 0);
        cyc(1, 1, 0, 32'hAA, 1, 0, 0);
        chk("midrst_addr", addr, 0); chk("midrst_valid", valid, 0); chk("midrst_full", ckpt_full, 0);
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 199) == 0;
            fl = $urandom_range(0, 15) == 0;
            p  = 1'($urandom);
            o  = 1'($urandom);
            bf = 1'($urandom);
            br = $urandom_range(0, 2) == 0;
            if (bf && !br && q.size() == NUM_CKPT) bf = 1'b0;
            cyc(r, p, o, $urandom, bf, br, fl);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
